// File: rtl/dsp_cic_comp_pkg.sv
// Shared types and sizing helpers for the CIC droop compensation FIR.
// Sizing functions keep the top and MAC datapath widths consistent.
package dsp_cic_comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUT
  } state_e;

  function automatic int calc_h(input int ntap);
    return (ntap + 1) / 2;
  endfunction

  function automatic int calc_aw(input int ntap);
    return $clog2(calc_h(ntap));
  endfunction

  function automatic int calc_accw(input int bin, input int cw,
                                   input int ntap);
    return bin + 1 + cw + $clog2(calc_h(ntap));
  endfunction

  // Unity centre tap scaled by the output shift: a pure delay filter.
  function automatic int rst_coef(input int idx, input int h,
                                  input int cshift);
    return (idx == h - 1) ? (1 << cshift) : 0;
  endfunction

endpackage

// File: rtl/dsp_sym_mac.sv
// Three-stage symmetric MAC: pre-add, signed product, accumulate.
// Valid and clear travel with the data so the accumulator restarts per pass.
module dsp_sym_mac
  import dsp_cic_comp_pkg::*;
#(
  parameter int BIN  = 16,
  parameter int CW   = 18,
  parameter int ACCW = 39
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic signed [BIN-1:0]  a,
  input  logic signed [BIN-1:0]  b,
  input  logic signed [CW-1:0]   coef,
  output logic signed [ACCW-1:0] acc
);

  localparam int PW = BIN + 1 + CW;

  logic signed [BIN:0]    pre_q, pre_d;
  logic signed [CW-1:0]   cf_q, cf_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic v1_q, v1_d, c1_q, c1_d;
  logic v2_q, v2_d, c2_q, c2_d;

  always_comb begin
    pre_d  = {a[BIN-1], a} + {b[BIN-1], b};
    cf_d   = coef;
    v1_d   = en;
    c1_d   = clr;
    prod_d = PW'(pre_q) * PW'(cf_q);
    v2_d   = v1_q;
    c2_d   = c1_q;
    acc_d  = acc_q;
    if (v2_q) begin
      acc_d = (c2_q ? '0 : acc_q) + ACCW'(prod_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      cf_q   <= '0;
      v1_q   <= 1'b0;
      c1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
      c2_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      cf_q   <= cf_d;
      v1_q   <= v1_d;
      c1_q   <= c1_d;
      prod_q <= prod_d;
      v2_q   <= v2_d;
      c2_q   <= c2_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dsp_cic_comp_fir.sv
// Time-multiplexed symmetric FIR compensating CIC sinc droop.
// One MAC pass per accepted sample; coefficients programmable when idle.
module dsp_cic_comp_fir
  import dsp_cic_comp_pkg::*;
#(
  parameter int BIN    = 16,
  parameter int BOUT   = 16,
  parameter int NTAP   = 21,
  parameter int CW     = 18,
  parameter int CSHIFT = 16,
  localparam int H     = calc_h(NTAP),
  localparam int AW    = calc_aw(NTAP),
  localparam int ACCW  = calc_accw(BIN, CW, NTAP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [BIN-1:0] din,
  input  logic                  din_vld,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic signed [CW-1:0]  coef_din,
  output logic signed [BOUT-1:0] dout,
  output logic                  dout_vld,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PW  = $clog2(NTAP);
  localparam int CNW = (AW < 2) ? 2 : AW;
  localparam logic signed [ACCW:0] RND  = (ACCW+1)'(1) << (CSHIFT-1);
  localparam logic signed [ACCW:0] MAXV = (ACCW+1)'((1 << (BOUT-1)) - 1);
  localparam logic signed [ACCW:0] MINV = -MAXV - 1;

  state_e state_q, state_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, ia_q, ia_d, ib_q, ib_d;
  logic signed [BIN-1:0] sbuf_q [NTAP];
  logic signed [BIN-1:0] sbuf_d [NTAP];
  logic signed [CW-1:0] coef_q [H];
  logic signed [CW-1:0] coef_d [H];
  logic signed [BOUT-1:0] dout_q, dout_d;
  logic ovf_q, ovf_d;

  logic accept, mac_en, mac_clr, centre;
  logic signed [BIN-1:0] op_a, op_b;
  logic signed [CW-1:0] op_c;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW:0] rsum, rshift;

  function automatic logic [PW-1:0] p_inc(input logic [PW-1:0] p);
    return (p == PW'(NTAP-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] p_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(NTAP-1) : p - 1'b1;
  endfunction

  assign busy     = (state_q == S_MAC) || (state_q == S_DRAIN);
  assign dout_vld = (state_q == S_OUT);
  assign accept   = din_vld &&
                    ((state_q == S_IDLE) || (state_q == S_OUT));

  // Walk newest-forward on ia and oldest-backward on ib to pair taps.
  assign centre  = (cnt_q == CNW'(H-1));
  assign mac_en  = (state_q == S_MAC);
  assign mac_clr = mac_en && (cnt_q == '0);
  assign op_a    = sbuf_q[ia_q];
  assign op_b    = centre ? '0 : sbuf_q[ib_q];
  assign op_c    = coef_q[cnt_q[AW-1:0]];

  always_comb begin
    rsum   = {acc[ACCW-1], acc} + RND;
    rshift = rsum >>> CSHIFT;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    sbuf_d  = sbuf_q;
    coef_d  = coef_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q | (din_vld & ~accept);

    if (coef_we && !busy && (coef_addr <= AW'(H-1))) begin
      coef_d[coef_addr] = coef_din;
    end

    unique case (state_q)
      S_IDLE, S_OUT: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d      = S_MAC;
          cnt_d        = '0;
          sbuf_d[wp_q] = din;
          wp_d         = p_inc(wp_q);
          ia_d         = wp_q;
          ib_d         = p_inc(wp_q);
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + 1'b1;
        ia_d  = p_dec(ia_q);
        ib_d  = p_inc(ib_q);
        if (centre) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNW'(2)) begin
          state_d = S_OUT;
          cnt_d   = '0;
          if (rshift > MAXV) begin
            dout_d = {1'b0, {(BOUT-1){1'b1}}};
          end else if (rshift < MINV) begin
            dout_d = {1'b1, {(BOUT-1){1'b0}}};
          end else begin
            dout_d = rshift[BOUT-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wp_q    <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NTAP; i++) sbuf_q[i] <= '0;
      for (int i = 0; i < H; i++) begin
        coef_q[i] <= CW'(rst_coef(i, H, CSHIFT));
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      sbuf_q  <= sbuf_d;
      coef_q  <= coef_d;
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;

  dsp_sym_mac #(
    .BIN  (BIN),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en),
    .clr  (mac_clr),
    .a    (op_a),
    .b    (op_b),
    .coef (op_c),
    .acc  (acc)
  );

endmodule

// File: tb/tb_dsp_cic_comp_fir.sv
// Directed bench for dsp_cic_comp_fir: constant-input table plus
// impulse, overrun, busy-write, mid-pass reset and latency sequences.
module tb_dsp_cic_comp_fir;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] din = '0;
  logic din_vld = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [17:0] coef_din = '0;
  logic signed [15:0] dout;
  logic dout_vld, busy, ovf;

  int cyc = 0;
  int npass = 0;
  int ntot = 0;
  int outs[$];
  int ocyc[$];

  typedef struct {
    string name;
    int    side;
    int    ctr;
    int    dval;
    int    expv;
  } vec_t;

  vec_t tbl[8];

  dsp_cic_comp_fir dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_din  (coef_din),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_vld) begin
      outs.push_back(int'(dout));
      ocyc.push_back(cyc);
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    ntot++;
    if (act == expv) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  function automatic int getv(input int i);
    return (i < outs.size()) ? outs[i] : 32'h7fff_ffff;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_vld = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic prog(input int side, input int ctr);
    for (int a = 0; a < 11; a++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_din  = 18'((a == 10) ? ctr : side);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pulse(input int v, output int t);
    @(negedge clk);
    t = cyc;
    din = 16'(v);
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic play_const(input int v, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      pulse(v, t);
      idle(13);
    end
  endtask

  task automatic clear_outs();
    outs.delete();
    ocyc.delete();
  endtask

  initial begin
    int t0, t1;

    tbl[0] = '{"flat_pos",   4096,  4096,  16384,  21504};
    tbl[1] = '{"flat_neg",   4096,  4096, -16384, -21504};
    tbl[2] = '{"flat_small", 4096,  4096,    100,    131};
    tbl[3] = '{"sat_pos",   32768, 32768,  32767,  32767};
    tbl[4] = '{"sat_neg",   32768, 32768, -32768, -32768};
    tbl[5] = '{"ident",         0, 65536,   1234,   1234};
    tbl[6] = '{"half_up",       0,     2,  16384,      1};
    tbl[7] = '{"half_neg",      0,     2, -16384,      0};

    do_reset();
    check("rst_dout", int'(dout), 0);
    check("rst_vld", int'(dout_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);

    // Impulse through the reset (pure delay) coefficients.
    clear_outs();
    play_const(1000, 1);
    play_const(0, 20);
    idle(20);
    check("imp_count", outs.size(), 21);
    for (int i = 0; i < 21; i++) begin
      check($sformatf("imp_out%0d", i), getv(i), (i == 10) ? 1000 : 0);
    end
    check("imp_ovf", int'(ovf), 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      prog(tbl[r].side, tbl[r].ctr);
      clear_outs();
      play_const(tbl[r].dval, 22);
      idle(20);
      check({tbl[r].name, "_count"}, outs.size(), 22);
      check(tbl[r].name, getv(21), tbl[r].expv);
      check({tbl[r].name, "_ovf"}, int'(ovf), 0);
    end

    // Overrun: second strobe five cycles in lands during MAC.
    do_reset();
    clear_outs();
    pulse(1000, t0);
    idle(3);
    pulse(555, t1);
    check("ovr_flag", int'(ovf), 1);
    idle(8);
    play_const(0, 10);
    idle(20);
    check("ovr_count", outs.size(), 11);
    check("ovr_first", getv(0), 0);
    check("ovr_pos9", getv(9), 0);
    check("ovr_pos10", getv(10), 1000);
    check("ovr_sticky", int'(ovf), 1);

    // Coefficient writes while busy must be ignored.
    do_reset();
    clear_outs();
    pulse(500, t0);
    check("bw_busy", int'(busy), 1);
    coef_we   = 1'b1;
    coef_addr = 4'd10;
    coef_din  = '0;
    idle(3);
    coef_we = 1'b0;
    idle(10);
    play_const(0, 10);
    idle(20);
    check("bw_count", outs.size(), 11);
    check("bw_pos9", getv(9), 0);
    check("bw_pos10", getv(10), 500);
    check("bw_hold", int'(dout), 500);

    // Reset at MAC step 4 aborts the pass.
    clear_outs();
    pulse(700, t0);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_dout", int'(dout), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_vld", int'(dout_vld), 0);
    idle(25);
    check("mr_noout", outs.size(), 0);
    clear_outs();
    play_const(1234, 1);
    play_const(0, 10);
    idle(20);
    check("mr_pos0", getv(0), 0);
    check("mr_pos10", getv(10), 1234);

    // Latency and back-to-back acceptance in OUT.
    do_reset();
    clear_outs();
    pulse(77, t0);
    idle(13);
    pulse(88, t1);
    idle(30);
    check("lat_count", outs.size(), 2);
    check("lat_first", (ocyc.size() > 0) ? ocyc[0] - t0 : -1, 15);
    check("lat_second", (ocyc.size() > 1) ? ocyc[1] - t1 : -1, 15);
    check("lat_b2b_gap", t1 - t0, 15);
    check("lat_ovf", int'(ovf), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/dsp_cic_comp_fir.md
# dsp_cic_comp_fir

Time-multiplexed symmetric FIR that compensates the sinc droop of the CIC decimator. It sits directly downstream of the decimator and consumes its clipped output (`dout_cut`) and valid strobe. Each accepted sample is filtered with one multiplier, using the idle cycles between decimated samples. Coefficients are run-time programmable, because the droop depends on the selected decimation factor.

## Interface
- `BIN`, 16: input width, two's complement.
- `BOUT`, 16: output width, two's complement.
- `NTAP`, 21: tap count; must be odd and ≥3.
- `CW`, 18: coefficient width, signed.
- `CSHIFT`, 16: output scaling right-shift; must satisfy 1 ≤ `CSHIFT` ≤ `CW`-2.
- Derived values:
  - `H` = (`NTAP`+1)/2, the stored unique coefficients.
  - `AW` = clog2(`H`).
  - `ACCW` = `BIN`+1+`CW`+clog2(`H`).
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `din` in `BIN`: input sample, connected to the decimator's `dout_cut`.
- `din_vld` in 1: single-cycle sample strobe, connected to the decimator's `dout_vld`.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in `AW`: coefficient index, 0..`H`-1. Index `H`-1 is the centre tap.
- `coef_din` in `CW`: signed coefficient value.
- `dout` in/out: out `BOUT`. Filtered sample, held until the next result.
- `dout_vld` out 1: one-cycle strobe marking a new `dout`.
- `busy` out 1: high while a MAC pass is in progress.
- `ovf` out 1: sticky overrun flag; cleared only by `rst`.

## Operation
- **Filter definition.**
  - y[n] = Σ_{k=0}^{NTAP-1} h[k]·x[n-k], with h[k] = h[NTAP-1-k] = c[k] for k < `H`.
  - x[0] is the newest sample.
- **Sample buffer.**
  - `NTAP`-deep circular buffer with a write pointer that wraps from `NTAP`-1 to 0.
  - An accepted `din` overwrites the oldest entry.
- **Accepting samples.** `din_vld` is accepted when the FSM is in IDLE, or in the same cycle that `dout_vld` is high.
- **Overrun.** `din_vld` in any other cycle:
  - the sample is dropped and the buffer and MAC are untouched;
  - `ovf` goes to 1 on the next edge.
- **FSM states.**
  - IDLE → MAC when a sample is accepted.
  - MAC lasts `H` cycles. Step k issues the pre-add x[k]+x[NTAP-1-k], sign-extended to `BIN`+1 bits, together with c[k].
  - The centre step (k=`H`-1) uses x[`H`-1] alone; it is not doubled.
  - MAC → DRAIN. DRAIN covers 3 cycles for the pre-add, product and accumulate pipeline.
  - DRAIN → OUT, which lasts 1 cycle and asserts `dout_vld`.
  - OUT → IDLE, or OUT → MAC if `din_vld` is high in that cycle.
- **Arithmetic.**
  - The accumulator is `ACCW` bits and is cleared at the start of each pass.
  - `dout` = sat_BOUT((acc + 2^(CSHIFT-1)) >>> CSHIFT). This rounds half toward +∞.
  - Saturation is to [-2^(BOUT-1), 2^(BOUT-1)-1].
- **Coefficient writes.**
  - `coef_we` is honoured only while `busy`=0, and takes effect from the next pass.
  - `coef_we` while `busy`=1 is ignored.
- **Reset values.**
  - Buffer is all 0 and the write pointer is 0.
  - `dout`=0, `dout_vld`=0, `busy`=0, `ovf`=0, FSM in IDLE.
  - Coefficients: c[H-1] = 2^CSHIFT and all others 0. This makes the filter a pure delay of (`NTAP`-1)/2 samples.
- **Reset mid-pass.** `rst` during MAC or DRAIN aborts the pass: no `dout_vld` is produced and all state returns to reset values on that edge.

## Timing
- A `din_vld` accepted in cycle t gives `dout_vld` in cycle t+`H`+4. The latency L is 15 for the defaults.
- `busy` is high from t+1 through t+`H`+3.
- The minimum `din_vld` spacing without overrun is `H`+4 cycles. With the defaults this requires decimation R ≥ 15.
- `dout` updates on the same edge that raises `dout_vld`.

## Structure
- **Shared package `dsp_cic_comp_pkg`:**
  - functions for `H`, `AW` and `ACCW`;
  - the FSM state encoding (IDLE, MAC, DRAIN, OUT);
  - the reset-coefficient function.
- **Sub-module `dsp_sym_mac`:**
  - 3-stage pipeline: pre-add register, signed product register, accumulator;
  - inputs: clear and enable.
- **Top level:** buffer, coefficient register file, FSM, round/saturate and flags.

## Test plan
1. **Impulse through reset coefficients.** After reset, send din=1000 followed by zeros, with spacing 15. Expect `dout`=1000 on exactly the 11th `dout_vld` and 0 on every other strobe; `ovf`=0.
2. **Constant input, flat coefficients.** Program c[0..10]=4096 and drive din=16384 constantly. From the 21st output onward, expect `dout`=21504.
3. **Saturation.** With c[0..10]=32768:
   - din=32767 constant gives `dout`=32767;
   - din=-32768 constant gives `dout`=-32768.
4. **Overrun.** Send a second `din_vld` 5 cycles after the first. Expect `ovf`=1 and held, exactly one `dout_vld` for the pair, and the second sample absent from later outputs.
5. **Write while busy, then reset mid-pass.**
   - `coef_we` while `busy`=1 is ignored; the output is unchanged from the identity filter.
   - `rst` asserted at MAC step 4 gives no `dout_vld`; the next cycle has `dout`=0, `busy`=0 and identity coefficients.
6. **Latency and back-to-back.** A `din_vld` at cycle t gives `dout_vld` exactly at t+15, one cycle wide. Strobes at spacing 15, including one coincident with OUT, are all accepted with `ovf`=0.
